fetch_sequencer: RTL
====================

// Module: fetch_sequencer
//
// PURPOSE
// Program counter and fetch controller for the ASIP core. Drives the address of the
// combinational instruction memory and captures each returned word with its PC in a
// small prefetch buffer. Presents words to decode over a valid/ready handshake and
// accepts branch redirects from execute, flushing any stale prefetched words.
//
// PARAMETERS
// ADDR_W      8   instruction memory address width (byte address)
// INSTR_W     17  instruction word width
// DEPTH       2   prefetch buffer entries (>=1)
// PC_STEP     4   PC increment per fetched word
// RESET_ADDR  0   PC value after reset
//
// PORTS
// clk             in   1        core clock, all state on rising edge
// rst_n           in   1        synchronous active-low reset
// start           in   1        pulse: leave IDLE/HALT and begin fetching
// imem_addr       out  ADDR_W   address to instruction memory (= PC)
// imem_data       in   INSTR_W  word read from memory, valid same cycle (combinational)
// instr_valid     out  1        buffer head holds a word for decode
// instr_ready     in   1        decode accepts head this cycle
// instr           out  INSTR_W  head instruction word
// instr_pc        out  ADDR_W   PC of head word
// redirect_valid  in   1        branch taken: restart fetch at redirect_addr
// redirect_addr   in   ADDR_W   branch target
// busy            out  1        state == RUN
// halted          out  1        state == HALT (0 when HALT_DETECT_EN undefined)
// fetch_count     out  16       words pushed since reset, saturates at 16'hFFFF
//
// BEHAVIOUR
// - Reset (rst_n==0 at edge): state IDLE, PC=RESET_ADDR, buffer empty, fetch_count=0;
//   hence instr_valid=0, instr=0, instr_pc=0, busy=0, halted=0, imem_addr=RESET_ADDR.
//   Reset overrides every other input, including mid-operation with a full buffer.
// - States: IDLE -(start)-> RUN; RUN -(halt word, opt.)-> HALT; HALT -(start|redirect)-> RUN.
//   IDLE ignores redirect_valid except that PC loads redirect_addr.
// - imem_addr = PC continuously (combinational from register).
// - pop = instr_valid & instr_ready. push = RUN & !redirect_valid & (count<DEPTH | pop).
// - On push: entry {PC, imem_data} written at tail; PC <= PC + PC_STEP, mod 2^ADDR_W
//   (0xFC+4 -> 0x00); fetch_count increments (saturating).
// - Latency: start sampled at edge N -> RUN; first push at edge N+1; instr_valid=1 with
//   instr_pc=RESET_ADDR after edge N+1. Sustained throughput 1 word/cycle with ready=1.
// - Full and pop in same cycle: both happen; count unchanged; order preserved (FIFO).
// - Empty and pop impossible (instr_valid=0). Head outputs are 0 when empty.
// - redirect_valid (any state but IDLE): buffer flushed (count=0), PC <= redirect_addr,
//   no push that cycle; a pop in the same cycle counts as consumed. instr_valid=0 for
//   the next cycle; target word appears at head the cycle after that.
// - redirect and start in same cycle from HALT: go RUN, PC=redirect_addr.
// - redirect_addr used verbatim; no alignment forced.
//
// CONFIGURATION
// HALT_DETECT_EN defined: a pushed word equal to all-zeros is still enqueued, then state
//   moves to HALT (no further push, PC holds at halt PC+PC_STEP, halted=1); remaining
//   buffered words still drain to decode.
// HALT_DETECT_EN undefined: zero words are ordinary instructions; HALT unreachable;
//   halted tied 0.
//
// TESTING
// 1 Reset, start pulse, instr_ready=1 -> pcs 0x00,0x04,0x08.. one per cycle, first valid
//   2 edges after start, instr equals memory model word at each pc, fetch_count tracks.
// 2 instr_ready=0 after start -> exactly DEPTH words buffered, imem_addr holds 0x08;
//   ready=1 -> words 0x00,0x04,0x08.. in order, no gaps, no duplicates.
// 3 Buffer full, redirect_valid with redirect_addr=0x1C -> next cycle instr_valid=0,
//   following cycle instr_pc=0x1C; no word from 0x08 ever seen after redirect.
// 4 redirect_addr=0xFC, ready=1 -> instr_pc sequence 0xFC, 0x00, 0x04 (wrap).
// 5 HALT_DETECT_EN, memory zero at 0x2C -> word 0x2C delivered, halted=1, imem_addr
//   stays 0x30, no pushes; redirect to 0x00 -> halted=0, fetching resumes at 0x00.
// 6 rst_n=0 mid-run with full buffer -> after edge all outputs at reset values;
//   release + start -> fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC / fetch controller: drives combinational imem, buffers {pc, word} pairs for decode.
// Optional macro HALT_DETECT_EN: an all-zero fetched word parks the sequencer in HALT.
module fetch_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int INSTR_W    = 17,
   parameter int DEPTH      = 2,
   parameter int PC_STEP    = 4,
   parameter int RESET_ADDR = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               busy,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t             state, state_nx;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  buf_pc   [DEPTH];
   logic [INSTR_W-1:0] buf_data [DEPTH];
   logic [PW-1:0]      head, tail;
   logic [CW-1:0]      count;
   logic               pop, push, halt_hit;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop  = instr_valid & instr_ready;
   assign push = (state == RUN) & ~redirect_valid & ((count < CW'(DEPTH)) | pop);

`ifdef HALT_DETECT_EN
   assign halt_hit = push & (imem_data == '0);
`else
   assign halt_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (halt_hit) state_nx = HALT;
         HALT:    if (start | redirect_valid) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state == RUN);
`ifdef HALT_DETECT_EN
      halted = (state == HALT);
`else
      halted = 1'b0;
`endif
   end

   // PC, prefetch buffer and counter; a redirect wins over any push and drops the buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= ADDR_W'(RESET_ADDR);
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc    <= redirect_addr;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            buf_pc[tail]   <= pc;
            buf_data[tail] <= imem_data;
            tail           <= ptr_inc(tail);
            pc             <= pc + ADDR_W'(PC_STEP);
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
         end
         if (pop) head <= ptr_inc(head);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign imem_addr   = pc;
   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? buf_data[head] : '0;
   assign instr_pc    = instr_valid ? buf_pc[head]   : '0;

endmodule
